// File: rtl/fp_add_arbiter.sv
// Round-robin arbiter that time-shares one FP adder between N requesters,
// driving its level start / pulse done handshake with a timeout abort.
module fp_add_arbiter #(
  parameter int N       = 4,
  parameter int TIMEOUT = 64,
  parameter int DRAIN   = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req_i,
  input  logic [32*N-1:0] a_i,
  input  logic [32*N-1:0] b_i,
  output logic [N-1:0]    done_o,
  output logic [31:0]     res_o,
  output logic            err_o,
  output logic            busy_o,
  output logic            add_start,
  output logic [31:0]     add_a,
  output logic [31:0]     add_b,
  input  logic            add_done,
  input  logic [31:0]     add_res
);

  // state | meaning
  // IDLE  | waiting for any request, picks round-robin winner
  // WAIT  | adder running, timer counts toward TIMEOUT
  // RESP  | done_o pulse after a normal completion
  // FLUSH | done_o pulse after a timeout, then DRAIN cycles ignoring add_done
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_RESP  = 2'd2;
  localparam logic [1:0] S_FLUSH = 2'd3;

  localparam int PW   = (N > 1) ? $clog2(N) : 1;
  localparam int TMAX = (TIMEOUT > DRAIN) ? TIMEOUT : DRAIN;
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] DR_LAST = TW'(DRAIN - 1);
  localparam logic [PW-1:0] CH_LAST = PW'(N - 1);

  logic [1:0]    r_state;
  logic [PW-1:0] r_ptr;
  logic [PW-1:0] r_gnt;
  logic [TW-1:0] r_timer;
  logic [N-1:0]  r_done;
  logic [31:0]   r_res;
  logic          r_err;
  logic          r_busy;
  logic          r_start;
  logic [31:0]   r_a;
  logic [31:0]   r_b;

  logic          w_any;
  logic          w_hi_found;
  logic [PW-1:0] w_hi_idx;
  logic [PW-1:0] w_lo_idx;
  logic [PW-1:0] w_win;
  logic [31:0]   w_win_a;
  logic [31:0]   w_win_b;
  logic [N-1:0]  w_gnt_oh;
  logic [PW-1:0] w_ptr_nxt;

  // Lowest set bit at or above the pointer, else the lowest set bit overall (wrap).
  always_comb begin
    w_any      = 1'b0;
    w_hi_found = 1'b0;
    w_hi_idx   = '0;
    w_lo_idx   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req_i[k]) begin
        w_any    = 1'b1;
        w_lo_idx = PW'(k);
        if (PW'(k) >= r_ptr) begin
          w_hi_found = 1'b1;
          w_hi_idx   = PW'(k);
        end
      end
    end
    w_win = w_hi_found ? w_hi_idx : w_lo_idx;
  end

  always_comb begin
    w_win_a = '0;
    w_win_b = '0;
    for (int k = 0; k < N; k++) begin
      if (w_win == PW'(k)) begin
        w_win_a = a_i[32*k +: 32];
        w_win_b = b_i[32*k +: 32];
      end
    end
  end

  assign w_gnt_oh  = {{(N-1){1'b0}}, 1'b1} << r_gnt;
  assign w_ptr_nxt = (r_gnt == CH_LAST) ? '0 : r_gnt + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_gnt   <= '0;
      r_timer <= '0;
      r_done  <= '0;
      r_res   <= '0;
      r_err   <= 1'b0;
      r_busy  <= 1'b0;
      r_start <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
    end else begin
      r_done <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_gnt   <= w_win;
            r_a     <= w_win_a;
            r_b     <= w_win_b;
            r_start <= 1'b1;
            r_timer <= '0;
            r_busy  <= 1'b1;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          r_timer <= r_timer + 1'b1;
          // A result arriving on the last allowed cycle still counts as success.
          if (add_done) begin
            r_start <= 1'b0;
            r_res   <= add_res;
            r_err   <= 1'b0;
            r_done  <= w_gnt_oh;
            r_ptr   <= w_ptr_nxt;
            r_state <= S_RESP;
          end else if (r_timer == TO_LAST) begin
            r_start <= 1'b0;
            r_res   <= '0;
            r_err   <= 1'b1;
            r_done  <= w_gnt_oh;
            r_ptr   <= w_ptr_nxt;
            r_timer <= '0;
            r_state <= S_FLUSH;
          end
        end
        S_RESP: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        S_FLUSH: begin
          r_timer <= r_timer + 1'b1;
          if (r_timer == DR_LAST) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_start <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign done_o    = r_done;
  assign res_o     = r_res;
  assign err_o     = r_err;
  assign busy_o    = r_busy;
  assign add_start = r_start;
  assign add_a     = r_a;
  assign add_b     = r_b;

endmodule

// File: tb/tb_fp_add_arbiter.sv
// Directed bench for fp_add_arbiter; the adder handshake is driven by hand
// from the stimulus sequence.
module tb_fp_add_arbiter;

  localparam int N       = 4;
  localparam int TIMEOUT = 64;
  localparam int DRAIN   = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_i;
  logic [32*N-1:0] a_i;
  logic [32*N-1:0] b_i;
  logic [N-1:0]    done_o;
  logic [31:0]     res_o;
  logic            err_o;
  logic            busy_o;
  logic            add_start;
  logic [31:0]     add_a;
  logic [31:0]     add_b;
  logic            add_done;
  logic [31:0]     add_res;

  int tests = 0;
  int fails = 0;

  fp_add_arbiter #(.N(N), .TIMEOUT(TIMEOUT), .DRAIN(DRAIN)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_i     (req_i),
    .a_i       (a_i),
    .b_i       (b_i),
    .done_o    (done_o),
    .res_o     (res_o),
    .err_o     (err_o),
    .busy_o    (busy_o),
    .add_start (add_start),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_done  (add_done),
    .add_res   (add_res)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Wait for the grant, answer after lat cycles, check the completion and the IDLE gap.
  task automatic run_op(input string tag, input logic [N-1:0] exp_done,
                        input logic [31:0] sum, input int lat);
    int n;
    n = 0;
    while (add_start !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk({tag, "_start"}, add_start, 32'd1);
    for (int i = 1; i < lat; i++) step();
    add_done = 1'b1;
    add_res  = sum;
    step();
    add_done = 1'b0;
    add_res  = '0;
    chk({tag, "_done"}, done_o, exp_done);
    chk({tag, "_res"}, res_o, sum);
    chk({tag, "_err"}, err_o, 32'd0);
    chk({tag, "_start_lo1"}, add_start, 32'd0);
    chk({tag, "_busy_resp"}, busy_o, 32'd1);
    step();
    chk({tag, "_done_clr"}, done_o, 32'd0);
    chk({tag, "_busy_idle"}, busy_o, 32'd0);
    chk({tag, "_start_lo2"}, add_start, 32'd0);
  endtask

  initial begin
    logic [N-1:0] oh;
    int n;
    rst      = 1'b1;
    req_i    = '0;
    a_i      = '0;
    b_i      = '0;
    add_done = 1'b0;
    add_res  = '0;
    step();
    step();
    chk("rst_start", add_start, 32'd0);
    chk("rst_a", add_a, 32'd0);
    chk("rst_b", add_b, 32'd0);
    chk("rst_done", done_o, 32'd0);
    chk("rst_res", res_o, 32'd0);
    chk("rst_err", err_o, 32'd0);
    chk("rst_busy", busy_o, 32'd0);

    // Single request on ch2: 1.0 + 2.0 = 3.0
    rst           = 1'b0;
    req_i         = 4'b0100;
    a_i[64 +: 32] = 32'h3F800000;
    b_i[64 +: 32] = 32'h40000000;
    step();
    chk("t1_start", add_start, 32'd1);
    chk("t1_a", add_a, 32'h3F800000);
    chk("t1_b", add_b, 32'h40000000);
    chk("t1_busy", busy_o, 32'd1);
    run_op("t1", 4'b0100, 32'h40400000, 1);
    req_i = '0;

    // All four held: grants rotate 0,1,2,3,0
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int k = 0; k < N; k++) begin
      a_i[32*k +: 32] = 32'h3F800000;
      b_i[32*k +: 32] = 32'h3F800000;
    end
    req_i = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      oh = N'(1) << (i % N);
      run_op($sformatf("t2_op%0d", i), oh, 32'h40000000, 1 + (i % N));
    end
    req_i = '0;

    // Timeout on ch0 with a silent adder, late add_done during FLUSH
    req_i = 4'b0001;
    n = 0;
    while (add_start !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk("t3_start", add_start, 32'd1);
    for (int k = 1; k < TIMEOUT; k++) step();
    chk("t3_not_yet", done_o, 32'd0);
    step();
    chk("t3_done", done_o, 32'h1);
    chk("t3_err", err_o, 32'd1);
    chk("t3_res", res_o, 32'd0);
    chk("t3_start_lo", add_start, 32'd0);
    chk("t3_busy", busy_o, 32'd1);
    req_i = '0;
    step();
    step();
    add_done = 1'b1;
    add_res  = 32'h12345678;
    step();
    add_done = 1'b0;
    add_res  = '0;
    chk("t3_late_ignored", done_o, 32'd0);
    for (int k = 0; k < 4; k++) step();
    chk("t3_flush_busy", busy_o, 32'd1);
    chk("t3_flush_done", done_o, 32'd0);
    chk("t3_flush_res", res_o, 32'd0);
    step();
    chk("t3_flush_end", busy_o, 32'd0);

    // Normal service after the flush: ch3, 2.0 + 1.0
    a_i[96 +: 32] = 32'h40000000;
    b_i[96 +: 32] = 32'h3F800000;
    req_i = 4'b1000;
    run_op("t3_next", 4'b1000, 32'h40400000, 3);
    req_i = '0;

    // add_done on the very last WAIT cycle wins over the timeout
    req_i = 4'b0010;
    n = 0;
    while (add_start !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk("t4_start", add_start, 32'd1);
    for (int k = 1; k < TIMEOUT; k++) step();
    add_done = 1'b1;
    add_res  = 32'h41200000;
    step();
    add_done = 1'b0;
    add_res  = '0;
    chk("t4_done", done_o, 32'b0010);
    chk("t4_err", err_o, 32'd0);
    chk("t4_res", res_o, 32'h41200000);
    req_i = '0;
    step();
    chk("t4_no_flush", busy_o, 32'd0);

    // Reset in the middle of WAIT, ch3 held through reset
    a_i[64 +: 32] = 32'h40A00000;
    a_i[96 +: 32] = 32'h40E00000;
    b_i[96 +: 32] = 32'h3F800000;
    req_i = 4'b0100;
    n = 0;
    while (add_start !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk("t5_pre_a", add_a, 32'h40A00000);
    step();
    step();
    rst   = 1'b1;
    req_i = 4'b1000;
    step();
    chk("t5_start", add_start, 32'd0);
    chk("t5_a", add_a, 32'd0);
    chk("t5_b", add_b, 32'd0);
    chk("t5_done", done_o, 32'd0);
    chk("t5_res", res_o, 32'd0);
    chk("t5_err", err_o, 32'd0);
    chk("t5_busy", busy_o, 32'd0);
    rst = 1'b0;
    step();
    chk("t5_regrant", add_start, 32'd1);
    chk("t5_regrant_a", add_a, 32'h40E00000);
    chk("t5_regrant_b", add_b, 32'h3F800000);
    run_op("t5_op", 4'b1000, 32'h41000000, 2);
    req_i = '0;

    // Stray add_done while IDLE
    add_done = 1'b1;
    add_res  = 32'hDEADBEEF;
    step();
    add_done = 1'b0;
    add_res  = '0;
    chk("idle_done_ignored", done_o, 32'd0);
    chk("idle_busy", busy_o, 32'd0);
    step();
    chk("idle_res_held", res_o, 32'h41000000);

    // ch1 drops its request mid-WAIT, ch2 waiting
    a_i[32 +: 32] = 32'h40000000;
    b_i[32 +: 32] = 32'h40000000;
    a_i[64 +: 32] = 32'h40400000;
    b_i[64 +: 32] = 32'h3F800000;
    req_i = 4'b0110;
    n = 0;
    while (add_start !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk("t6_ch1_a", add_a, 32'h40000000);
    step();
    req_i = 4'b0100;
    run_op("t6_ch1", 4'b0010, 32'h40800000, 2);
    step();
    chk("t6_ch2_start", add_start, 32'd1);
    chk("t6_ch2_a", add_a, 32'h40400000);
    chk("t6_ch2_b", add_b, 32'h3F800000);
    run_op("t6_ch2", 4'b0100, 32'h40800000, 1);
    req_i = '0;
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fp_add_arbiter.md
Name: fp_add_arbiter

Overview:
Round-robin arbiter and sequencer that shares one single-precision FP adder FSM between N requesters. It samples the winning requester's operands and drives the adder's level start / single-cycle done handshake. It returns the sum or a timeout error to that requester, then moves priority past it. It sits between several datapath clients and the team's 32-bit FP add unit.

Parameters:
N, 4, number of requesters (2..8)
TIMEOUT, 64, max cycles in WAIT before abort (>=16)
DRAIN, 8, cycles spent in FLUSH after a timeout

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
req_i  in  N  per-requester request, level, held until own done_o
a_i  in  32*N  operand A, requester k at [32k+31:32k]
b_i  in  32*N  operand B, same packing
done_o  out  N  one-hot, 1-cycle completion pulse to granted requester
res_o  out  32  result, valid with done_o, holds until next completion
err_o  out  1  1 with done_o when the op timed out (res_o=0)
busy_o  out  1  high in every state except IDLE
add_start  out  1  adder start, level
add_a  out  32  adder operand A (registered)
add_b  out  32  adder operand B (registered)
add_done  in  1  adder completion pulse, 1 cycle
add_res  in  32  adder result, valid while add_done=1

Behaviour:
- Reset: one clock, reset is synchronous and active-high. rst=1 at a clk edge forces all of the following, and overrides any operation in progress:
  - state IDLE
  - add_start=0, add_a=add_b=0
  - done_o=0, res_o=0, err_o=0, busy_o=0
  - rr pointer=0, timer=0, gnt=0
- States: IDLE, WAIT, RESP, FLUSH. All outputs are registered.
- IDLE, when any req_i is set:
  - Winner is the first set bit at index >= ptr, wrapping mod N.
  - Latch gnt=winner, add_a=a_i[winner], add_b=b_i[winner].
  - Set add_start=1, timer=0, go to WAIT.
  - Operands are sampled only at this edge.
- WAIT: timer increments every cycle.
  - add_done=1: add_start<=0, res_o<=add_res, err_o<=0, done_o<=onehot(gnt), ptr<=(gnt+1) mod N, go to RESP.
  - Else if timer==TIMEOUT-1: add_start<=0, res_o<=0, err_o<=1, done_o<=onehot(gnt), ptr<=(gnt+1) mod N, go to FLUSH.
  - add_done wins if both occur in the same cycle.
- RESP: done_o high for exactly this cycle, cleared at the next edge, then go to IDLE.
  - add_start stays low for at least 2 cycles after add_done, so the adder does not re-launch.
- FLUSH: done_o pulse as in RESP. Hold add_start=0 for DRAIN cycles, ignoring add_done (a late result is discarded), then go to IDLE.
- Latency: grant edge to done_o = adder latency + 1 cycle. Earliest next grant is 2 cycles after done_o.
- req_i changing while not in IDLE is ignored. A requester that drops req_i before its done_o still receives the pulse.
- A requester whose req_i is still high after its done_o is treated as a new request, at lowest priority.
- add_done seen in IDLE or RESP is ignored.
- Sign, exponent and mantissa handling is entirely inside the adder; the arbiter never alters data bits.

Test Plan:
1. Reset, then req_i=0100, a=0x3F800000, b=0x40000000 -> add_a/add_b match within 1 cycle, add_start=1. On add_done: done_o=0100 for 1 cycle, res_o=0x40400000, err_o=0.
2. req_i=1111 held, each channel a=b=0x3F800000 -> grants in order 0,1,2,3,0. Every done_o carries res_o=0x40000000. busy_o stays high except the IDLE cycle between ops.
3. Bench adder model never asserts add_done, req_i=0001 -> done_o=0001 with err_o=1, res_o=0 exactly TIMEOUT cycles after the grant. A late add_done during FLUSH produces no done_o. Next request is then served normally.
4. add_done arrives in the same cycle timer reaches TIMEOUT-1 -> normal completion with err_o=0 and res_o=add_res.
5. rst asserted mid-WAIT -> next cycle all outputs are 0, state IDLE, ptr=0. A request held on ch3 is granted 1 cycle after rst drops.
6. ch1 drops req_i mid-WAIT while ch2 is requesting -> ch1 still gets done_o=0010. Next grant goes to ch2, and add_start stays 0 for 2 cycles before it.
